// File: rtl/bar_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bar_pkg: shared types and constants for the bar-height controller  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bar_pkg;
  localparam int NUM_BARS = 16;
  localparam int HEIGHT_W = 9;
  localparam int MAX_H    = 480;
  localparam int MAG_W    = 16;
  localparam int IDX_W    = $clog2(NUM_BARS);

  typedef logic [HEIGHT_W-1:0] height_t;
  typedef logic [IDX_W-1:0]    bar_idx_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  // The shifted magnitude keeps full width so values above 511 still clip to MAX_H.
  function automatic height_t scale_mag(input logic [MAG_W-1:0] mag, input int shift);
    logic [MAG_W-1:0] shifted;
    shifted = mag >> shift;
    if (shifted > MAG_W'(MAX_H)) return height_t'(MAX_H);
    return height_t'(shifted);
  endfunction
endpackage
`default_nettype wire

// File: rtl/bar_height_ctrl_dynamics.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bar_dynamics: combinational attack/decay and peak-hold step        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bar_dynamics
  import bar_pkg::*;
#(
  parameter int DECAY       = 8,
  parameter int HOLD_FRAMES = 30,
  parameter int PEAK_DECAY  = 2,
  parameter int HOLD_W      = $clog2(HOLD_FRAMES + 1)
) (
  input  logic [HEIGHT_W-1:0] i_cur,
  input  logic [HEIGHT_W-1:0] i_target,
  input  logic [HEIGHT_W-1:0] i_peak,
  input  logic [HOLD_W-1:0]   i_hold,
  output logic [HEIGHT_W-1:0] o_height,
  output logic [HEIGHT_W-1:0] o_peak,
  output logic [HOLD_W-1:0]   o_hold
);
  localparam logic [HEIGHT_W-1:0] C_DECAY      = HEIGHT_W'(DECAY);
  localparam logic [HEIGHT_W-1:0] C_PEAK_DECAY = HEIGHT_W'(PEAK_DECAY);
  localparam logic [HOLD_W-1:0]   C_HOLD_INIT  = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0]   C_HOLD_ONE   = HOLD_W'(1);

  logic [HEIGHT_W-1:0] w_new_height;

  always_comb begin
    w_new_height = i_target;
    if (i_target < i_cur && (i_cur - i_target) > C_DECAY)
      w_new_height = i_cur - C_DECAY;

    o_height = w_new_height;
    o_peak   = i_peak;
    o_hold   = i_hold;
    if (w_new_height >= i_peak) begin
      o_peak = w_new_height;
      o_hold = C_HOLD_INIT;
    end else if (i_hold != '0) begin
      o_hold = i_hold - C_HOLD_ONE;
    end else if ((i_peak - w_new_height) > C_PEAK_DECAY) begin
      o_peak = i_peak - C_PEAK_DECAY;
    end else begin
      o_peak = w_new_height;
    end
  end
endmodule
`default_nettype wire

// File: rtl/bar_height_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bar_height_ctrl: frame-synchronous bar height / peak controller    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bar_height_ctrl
  import bar_pkg::*;
#(
  parameter int SHIFT       = 6,
  parameter int DECAY       = 8,
  parameter int HOLD_FRAMES = 30,
  parameter int PEAK_DECAY  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_mag_valid,
  output logic                         o_mag_ready,
  input  logic [IDX_W-1:0]             i_mag_bin,
  input  logic [MAG_W-1:0]             i_mag_value,
  input  logic                         i_frame_start,
  output logic [NUM_BARS*HEIGHT_W-1:0] o_height,
  output logic [NUM_BARS*HEIGHT_W-1:0] o_peak,
  output logic                         o_busy,
  output logic                         o_overrun
);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam bar_idx_t C_LAST_IDX = bar_idx_t'(NUM_BARS - 1);
  localparam bar_idx_t C_IDX_ONE  = bar_idx_t'(1);

  state_t             r_state;
  bar_idx_t           r_idx;
  logic               r_ready;
  logic               r_busy;
  logic               r_overrun;
  height_t            r_height [NUM_BARS];
  height_t            r_peak   [NUM_BARS];
  height_t            r_shadow [NUM_BARS];
  logic [HOLD_W-1:0]  r_hold   [NUM_BARS];

  logic               w_accept;
  height_t            w_target;
  height_t            w_new_height;
  height_t            w_new_peak;
  logic [HOLD_W-1:0]  w_new_hold;

  assign w_accept = i_mag_valid && r_ready;
  assign w_target = scale_mag(i_mag_value, SHIFT);

  // Single shared datapath walks the bars one per cycle.
  bar_dynamics #(
    .DECAY       (DECAY),
    .HOLD_FRAMES (HOLD_FRAMES),
    .PEAK_DECAY  (PEAK_DECAY),
    .HOLD_W      (HOLD_W)
  ) u_dyn (
    .i_cur    (r_height[r_idx]),
    .i_target (r_shadow[r_idx]),
    .i_peak   (r_peak[r_idx]),
    .i_hold   (r_hold[r_idx]),
    .o_height (w_new_height),
    .o_peak   (w_new_peak),
    .o_hold   (w_new_hold)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) begin
        r_height[i] <= '0;
        r_peak[i]   <= '0;
        r_shadow[i] <= '0;
        r_hold[i]   <= '0;
      end
    end else begin
      if (w_accept)
        r_shadow[i_mag_bin] <= w_target;
      case (r_state)
        IDLE: begin
          if (i_frame_start) begin
            r_state <= UPDATE;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        UPDATE: begin
          if (i_frame_start)
            r_overrun <= 1'b1;
          r_height[r_idx] <= w_new_height;
          r_peak[r_idx]   <= w_new_peak;
          r_hold[r_idx]   <= w_new_hold;
          r_shadow[r_idx] <= '0;
          r_idx           <= r_idx + C_IDX_ONE;
          if (r_idx == C_LAST_IDX) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_BARS; g++) begin : g_out
    assign o_height[g*HEIGHT_W +: HEIGHT_W] = r_height[g];
    assign o_peak[g*HEIGHT_W +: HEIGHT_W]   = r_peak[g];
  end

  assign o_mag_ready = r_ready;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_bar_height_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bar_height_ctrl: randomized bench with frame-level reference    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_bar_height_ctrl;
  localparam int NB = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_mag_valid;
  logic         o_mag_ready;
  logic [3:0]   i_mag_bin;
  logic [15:0]  i_mag_value;
  logic         i_frame_start;
  logic [143:0] o_height;
  logic [143:0] o_peak;
  logic         o_busy;
  logic         o_overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: one value per bar, advanced a whole frame at a time.
  int m_h[NB];
  int m_p[NB];
  int m_hold[NB];
  int m_shadow[NB];

  bar_height_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .i_mag_valid   (i_mag_valid),
    .o_mag_ready   (o_mag_ready),
    .i_mag_bin     (i_mag_bin),
    .i_mag_value   (i_mag_value),
    .i_frame_start (i_frame_start),
    .o_height      (o_height),
    .o_peak        (o_peak),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hgt(input int i);
    return int'(o_height[i*9 +: 9]);
  endfunction

  function automatic int pk(input int i);
    return int'(o_peak[i*9 +: 9]);
  endfunction

  function automatic int scale(input int v);
    int s;
    s = v / 64;
    return (s > 480) ? 480 : s;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_h[i] = 0; m_p[i] = 0; m_hold[i] = 0; m_shadow[i] = 0;
    end
  endtask

  task automatic write_beat(input int bin, input int val);
    i_mag_valid = 1'b1;
    i_mag_bin   = 4'(bin);
    i_mag_value = 16'(val);
    chk("ready_idle", int'(o_mag_ready), 1);
    m_shadow[bin] = scale(val);
    @(negedge clk);
    i_mag_valid = 1'b0;
  endtask

  // Pulses frame_start; optionally re-pulses it at cycle inj_k and adds a same-cycle beat.
  task automatic run_frame(input int inj_k, input bit with_beat, input int bbin, input int bval);
    int nh[NB];
    int np[NB];
    int nhold[NB];
    i_frame_start = 1'b1;
    if (with_beat) begin
      i_mag_valid = 1'b1;
      i_mag_bin   = 4'(bbin);
      i_mag_value = 16'(bval);
      m_shadow[bbin] = scale(bval);
    end
    for (int i = 0; i < NB; i++) begin
      int t;
      t = m_shadow[i];
      nh[i] = (t >= m_h[i]) ? t : imax(m_h[i] - 8, t);
      np[i] = m_p[i];
      nhold[i] = m_hold[i];
      if (nh[i] >= m_p[i]) begin
        np[i] = nh[i]; nhold[i] = 30;
      end else if (m_hold[i] > 0) begin
        nhold[i] = m_hold[i] - 1;
      end else begin
        np[i] = imax(m_p[i] - 2, nh[i]);
      end
    end
    @(negedge clk);
    i_frame_start = 1'b0;
    i_mag_valid   = 1'b0;
    chk("busy_start", int'(o_busy), 1);
    chk("ready_upd", int'(o_mag_ready), 0);
    for (int k = 1; k <= NB; k++) begin
      i_mag_valid   = 1'($urandom_range(0, 1));
      i_mag_bin     = 4'($urandom_range(0, 15));
      i_mag_value   = 16'($urandom_range(0, 65535));
      i_frame_start = (k == inj_k);
      @(negedge clk);
      i_frame_start = 1'b0;
      i_mag_valid   = 1'b0;
      chk($sformatf("height%0d", k-1), hgt(k-1), nh[k-1]);
      chk($sformatf("peak%0d", k-1), pk(k-1), np[k-1]);
      if (k < NB) begin
        chk($sformatf("height%0d_old", k), hgt(k), m_h[k]);
        chk("busy_mid", int'(o_busy), 1);
      end else begin
        chk("busy_end", int'(o_busy), 0);
        chk("ready_end", int'(o_mag_ready), 1);
      end
    end
    for (int i = 0; i < NB; i++) begin
      m_h[i] = nh[i]; m_p[i] = np[i]; m_hold[i] = nhold[i]; m_shadow[i] = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_mag_valid = 1'b0;
    i_mag_bin = '0;
    i_mag_value = '0;
    i_frame_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_height_vec_zero", int'(o_height == '0), 1);
    chk("rst_peak_vec_zero", int'(o_peak == '0), 1);
    chk("rst_ready", int'(o_mag_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_overrun", int'(o_overrun), 0);

    // Single bin attack.
    write_beat(3, 16'h3000);
    run_frame(0, 1'b0, 0, 0);
    chk("bin3_192", hgt(3), 192);
    chk("peak3_192", pk(3), 192);

    // Clip to MAX_H then linear decay to zero.
    write_beat(0, 16'hFFFF);
    run_frame(0, 1'b0, 0, 0);
    chk("bin0_clip", hgt(0), 480);
    for (int f = 0; f < 60; f++) run_frame(0, 1'b0, 0, 0);
    chk("bin0_zero", hgt(0), 0);

    // No overshoot below target.
    write_beat(0, 9 * 64);
    run_frame(0, 1'b0, 0, 0);
    write_beat(0, 5 * 64);
    run_frame(0, 1'b0, 0, 0);
    chk("bin0_to5", hgt(0), 5);

    // Boundary magnitudes around MAX_H.
    write_beat(1, 480 * 64);
    write_beat(2, 481 * 64);
    write_beat(4, 63);
    run_frame(0, 1'b0, 0, 0);

    // Peak hold then fall.
    write_beat(5, 320 * 64);
    run_frame(0, 1'b0, 0, 0);
    for (int f = 0; f < 36; f++) run_frame(0, 1'b0, 0, 0);
    chk("peak5_fallen", pk(5), 320 - 2 * 6);

    // frame_start while busy: ignored, overrun sticky.
    run_frame(5, 1'b0, 0, 0);
    chk("overrun_set", int'(o_overrun), 1);
    @(negedge clk);
    chk("no_restart", int'(o_busy), 0);

    // Last write wins, and a beat on the frame_start cycle counts.
    write_beat(7, 100 * 64);
    write_beat(7, 50 * 64);
    run_frame(0, 1'b1, 9, 200 * 64);
    chk("bin9_same_cycle", hgt(9), 200);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int nb;
      nb = $urandom_range(0, 5);
      for (int b = 0; b < nb; b++) begin
        int v;
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(28000, 65535) : $urandom_range(0, 20000);
        write_beat($urandom_range(0, 15), v);
      end
      if ($urandom_range(0, 3) == 0)
        run_frame(0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 65535));
      else
        run_frame(0, 1'b0, 0, 0);
    end
    chk("overrun_sticky", int'(o_overrun), 1);

    // Asynchronous reset in the middle of an update walk.
    write_beat(6, 16'hFFFF);
    write_beat(12, 16'h8000);
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_nonzero", int'(o_height != '0), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_height", int'(o_height == '0), 1);
    chk("mid_rst_peak", int'(o_peak == '0), 1);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_ready", int'(o_mag_ready), 1);
    chk("mid_rst_overrun", int'(o_overrun), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(0, 1'b0, 0, 0);
    chk("post_rst_overrun", int'(o_overrun), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
